seq_divider: RTL
================

Name: seq_divider

Overview:
- Multi-cycle integer divider for the MIPS32 datapath. It executes DIV and DIVU.
- Implements radix-2 restoring division using one subtract per cycle. This is the iterative inverse of the add/subtract path in the ALU.
- The quotient feeds the LO register and the remainder feeds the HI register.
- The control unit stalls on busy and captures the results on done.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse. Sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU. Sampled with start.
- dividend  input  WIDTH  numerator. Sampled with start.
- divisor  input  WIDTH  denominator. Sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when quotient and remainder become valid.
- quotient  output  WIDTH  result for LO.
- remainder  output  WIDTH  result for HI.
- div_by_zero  output  1  set with done when divisor was 0.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. busy, done, div_by_zero, quotient and remainder all go to 0. All internal registers are cleared.
- States: IDLE, CALC, FIN.
- IDLE:
  - If start = 1 and divisor ≠ 0:
    - Latch |dividend| and |divisor|. Magnitude is taken only when is_signed = 1 and the MSB is 1.
    - Latch sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend). Both are 0 when is_signed = 0.
    - Clear the partial remainder and set step count = 0. Go to CALC; busy = 1.
  - If start = 1 and divisor = 0:
    - Go to FIN directly with quotient = all ones, remainder = dividend (raw), div_by_zero = 1.
  - done is 0 in every cycle spent in IDLE.
- CALC, one step per clock:
  - {R, Q} shifts left by 1.
  - Compute trial = R − D at WIDTH+1 bits.
  - If trial is non-negative: R = trial and Q[0] = 1. Otherwise R is kept and Q[0] = 0.
  - After exactly WIDTH steps, go to FIN.
- FIN, one cycle:
  - quotient = sign_q ? −Q : Q, and remainder = sign_r ? −R : R. Both are registered; negation is modulo 2^WIDTH.
  - done = 1 for this single cycle and busy = 0 in the same cycle. Next state is IDLE.
- Latency:
  - The edge that samples start is edge 0. done is high in the cycle following edge WIDTH+1, which is edge 33 for WIDTH = 32.
  - For divide by zero, done is high in the cycle following edge 1.
- busy is high from edge 0 through edge WIDTH. It is low in the done cycle.
- Arithmetic rules:
  - The quotient truncates toward zero. The remainder takes the sign of the dividend.
  - The identity dividend = quotient·divisor + remainder holds mod 2^WIDTH.
- Signed overflow, −2^(WIDTH−1) / −1: result is quotient = 0x80000000 and remainder = 0. No flag is raised. This follows naturally from the unsigned magnitude path.
- start while busy or in FIN is ignored. No queueing and no restart.
- quotient, remainder and div_by_zero hold their values until the next FIN overwrites them. div_by_zero is cleared at the next FIN with a nonzero divisor.
- Reset asserted mid-operation aborts immediately to the reset values. No done is generated for the aborted operation.

Test Plan:
- Unsigned: start, is_signed = 0, 100 / 7 → done exactly 33 cycles after start. Expect quotient = 14, remainder = 2, div_by_zero = 0, and busy high for 33 cycles beforehand.
- Signed, mixed signs: −7 / 2 → quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF. Also check 7 / −2 → quotient = 0xFFFFFFFD, remainder = 1.
- Signed and unsigned extremes:
  - Signed 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0.
  - Unsigned 0xFFFFFFFF / 1 → quotient = 0xFFFFFFFF, remainder = 0.
  - Unsigned 5 / 9 → quotient = 0, remainder = 5.
- Divide by zero: 1234 / 0 → done one cycle after start. Expect quotient = 0xFFFFFFFF, remainder = 1234, div_by_zero = 1. A following 10 / 3 must clear div_by_zero and give quotient = 3, remainder = 1.
- Start while busy: issue 100 / 7, then start with 50 / 5 at cycle 10 → the second start is ignored. Exactly one done appears, with quotient = 14 and remainder = 2.
- Reset mid-operation: drop rst_n at cycle 15 of a division → all outputs go to 0 asynchronously and no done pulse follows. After release, a fresh 9 / 3 gives quotient = 3, remainder = 0 at the normal latency.

Source files
------------

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one trial subtract per clock, operating on
// magnitudes. The signs are re-applied when the result is registered on the way out of FIN.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;       // partial remainder
  logic [WIDTH-1:0] q_q, q_d;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d_q, d_d;       // divisor magnitude
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q_q, sgn_q_d;
  logic             sgn_r_q, sgn_r_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             neg_a, neg_b;
  logic [WIDTH:0]   shifted, trial;

  assign neg_a   = is_signed_i & dividend_i[WIDTH-1];
  assign neg_b   = is_signed_i & divisor_i[WIDTH-1];
  assign shifted = {r_q, q_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, d_q};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    sgn_q_d = sgn_q_q;
    sgn_r_d = sgn_r_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          busy_d = 1'b1;
          if (divisor_i != '0) begin
            q_d     = neg_a ? -dividend_i : dividend_i;
            d_d     = neg_b ? -divisor_i : divisor_i;
            r_d     = '0;
            sgn_q_d = neg_a ^ neg_b;
            sgn_r_d = neg_a;
            zero_d  = 1'b0;
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            // Divide by zero skips CALC; FIN's sign fix-up is a no-op with both signs clear.
            q_d     = '1;
            r_d     = dividend_i;
            d_d     = '0;
            sgn_q_d = 1'b0;
            sgn_r_d = 1'b0;
            zero_d  = 1'b1;
            state_d = FIN;
          end
        end
      end
      CALC: begin
        // A negative trial implies shifted < 2^WIDTH, so dropping its MSB is lossless.
        q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        r_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = FIN;
      end
      FIN: begin
        quot_d  = sgn_q_q ? -q_q : q_q;
        rem_d   = sgn_r_q ? -r_q : r_q;
        dbz_d   = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      sgn_q_q <= sgn_q_d;
      sgn_r_q <= sgn_r_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule
